alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath. Generalises the bit-sliced ALU to WIDTH bits. Keeps the legacy 3-bit operation encoding as single-cycle registered operations, and adds iterative unsigned multiply and divide behind a start/ready/valid handshake. It sits in EX and stalls the pipeline through `ready` while an iterative operation runs.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_nbit_comb.sv | 52 +++++
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 tb/tb_alu_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode localparams for the 4-bit alu_ctr field
//   - FSM state encoding
//   - iteration counter width helper ($clog2 of the datapath width)
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ANDN  = 4'b0100;
    localparam logic [3:0] OP_ORN   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_XOR2  = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter must hold WIDTH-1; $clog2(WIDTH) bits is enough for WIDTH >= 2.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/alu_nbit_comb.sv
// alu_nbit_comb: combinational WIDTH-bit single-cycle ALU datapath.
// Ports:
//   a_i, b_i    operands
//   op_i        alu_ctr[2:0]; bit 2 inverts b and forces carry-in to 1
//   result_o    AND / OR / ADD-SUB / XOR result
//   c_out_o     carry out of the MSB (ADD/SUB only, else 0)
//   overflow_o  carry into MSB xor carry out of MSB (ADD/SUB only, else 0)
module alu_nbit_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_out_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] low_sum_s;   // {carry into MSB, low WIDTH-1 sum bits}
    logic [1:0]       msb_sum_s;   // {carry out, MSB sum bit}
    logic [WIDTH-1:0] sum_s;

    assign b_eff_s   = op_i[2] ? ~b_i : b_i;
    // The adder is split at the MSB so the carry into it is visible for overflow.
    assign low_sum_s = {1'b0, a_i[WIDTH-2:0]} + {1'b0, b_eff_s[WIDTH-2:0]}
                     + {{(WIDTH-1){1'b0}}, op_i[2]};
    assign msb_sum_s = {1'b0, a_i[WIDTH-1]} + {1'b0, b_eff_s[WIDTH-1]}
                     + {1'b0, low_sum_s[WIDTH-1]};
    assign sum_s     = {msb_sum_s[0], low_sum_s[WIDTH-2:0]};

    // Lane select; the XOR lane always uses the uninverted b.
    always_comb begin
        result_o   = {WIDTH{1'b0}};
        c_out_o    = 1'b0;
        overflow_o = 1'b0;
        case ({1'b0, op_i})
            OP_AND, OP_ANDN: result_o = a_i & b_eff_s;
            OP_OR,  OP_ORN:  result_o = a_i | b_eff_s;
            OP_ADD, OP_SUB: begin
                result_o   = sum_s;
                c_out_o    = msb_sum_s[1];
                overflow_o = low_sum_s[WIDTH-1] ^ msb_sum_s[1];
            end
            OP_XOR, OP_XOR2: result_o = a_i ^ b_i;
            default:         result_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage.
// Single-cycle logic ops and ADD/SUB complete one cycle after start; MULTU
// (shift-add) and DIVU (restoring) take one bit per cycle and hold ready low.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, alu_ctr, a, b request and operands, sampled when ready=1
//   ready               idle, start accepted
//   valid               one-cycle pulse when results update
//   r, r_hi             result / MULTU high half or DIVU remainder
//   c_out, overflow     ADD/SUB flags, else 0
//   zero                r == 0
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;   // accumulator/remainder, multiplier/quotient, multiplicand/divisor
    logic             div_q;
    logic             ready_q, valid_q, c_out_q, ovf_q, zero_q;
    logic [WIDTH-1:0] r_q, r_hi_q;

    logic [WIDTH-1:0] comb_r_s, sc_r_s;
    logic             comb_c_s, comb_v_s, sc_c_s, sc_v_s;
    logic             is_iter_s;
    logic [WIDTH-1:0] cur_hi_s, cur_lo_s, cur_opnd_s;
    logic             cur_div_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] hi_d, lo_d;

    alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i        (a),
        .b_i        (b),
        .op_i       (alu_ctr[2:0]),
        .result_o   (comb_r_s),
        .c_out_o    (comb_c_s),
        .overflow_o (comb_v_s)
    );

    assign is_iter_s = (alu_ctr == OP_MULTU) || (alu_ctr == OP_DIVU);

    // Single-cycle result; reserved codes (bit 3 set, not MULTU/DIVU) give 0.
    always_comb begin
        if (alu_ctr[3]) begin
            sc_r_s = {WIDTH{1'b0}};
            sc_c_s = 1'b0;
            sc_v_s = 1'b0;
        end else begin
            sc_r_s = comb_r_s;
            sc_c_s = comb_c_s;
            sc_v_s = comb_v_s;
        end
    end

    // Iteration source: the first step runs on the start edge straight from the
    // input operands, so WIDTH steps fit in the start edge plus WIDTH-1 RUN cycles.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_hi_s   = {WIDTH{1'b0}};
            cur_lo_s   = (alu_ctr == OP_DIVU) ? a : b;
            cur_opnd_s = (alu_ctr == OP_DIVU) ? b : a;
            cur_div_s  = (alu_ctr == OP_DIVU);
        end else begin
            cur_hi_s   = hi_q;
            cur_lo_s   = lo_q;
            cur_opnd_s = opnd_q;
            cur_div_s  = div_q;
        end
    end

    assign add_s   = {1'b0, cur_hi_s} + {1'b0, cur_opnd_s};
    assign ge_s    = {cur_hi_s, cur_lo_s[WIDTH-1]} >= {1'b0, cur_opnd_s};
    // When ge_s holds the difference is below the divisor, so WIDTH bits suffice.
    assign trial_s = {cur_hi_s[WIDTH-2:0], cur_lo_s[WIDTH-1]} - cur_opnd_s;

    // One shift-add or restoring-division step.
    always_comb begin
        if (cur_div_s) begin
            if (ge_s) begin
                hi_d = trial_s;
                lo_d = {cur_lo_s[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {cur_hi_s[WIDTH-2:0], cur_lo_s[WIDTH-1]};
                lo_d = {cur_lo_s[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (cur_lo_s[0]) begin
                hi_d = add_s[WIDTH:1];
                lo_d = {add_s[0], cur_lo_s[WIDTH-1:1]};
            end else begin
                hi_d = {1'b0, cur_hi_s[WIDTH-1:1]};
                lo_d = {cur_hi_s[0], cur_lo_s[WIDTH-1:1]};
            end
        end
    end

    // FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            div_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            r_q      <= {WIDTH{1'b0}};
            r_hi_q   <= {WIDTH{1'b0}};
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && is_iter_s) begin
                        state_q <= ST_RUN;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        opnd_q  <= cur_opnd_s;
                        div_q   <= cur_div_s;
                        ready_q <= 1'b0;
                    end else if (start) begin
                        valid_q <= 1'b1;
                        r_q     <= sc_r_s;
                        r_hi_q  <= {WIDTH{1'b0}};
                        c_out_q <= sc_c_s;
                        ovf_q   <= sc_v_s;
                        zero_q  <= (sc_r_s == {WIDTH{1'b0}});
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        r_q     <= lo_d;
                        r_hi_q  <= hi_d;
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= (lo_d == {WIDTH{1'b0}});
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign valid    = valid_q;
    assign r        = r_q;
    assign r_hi     = r_hi_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=8 and WIDTH=32.
// Stimulus pushes hand-computed expected results; per-instance monitors pop
// and compare on every valid pulse.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic [31:0] hi;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q8[$];
    exp_t q32[$];
    exp_t e8, e32;

    logic        rst8, start8, ready8, valid8, c8, v8, z8;
    logic [3:0]  ctr8;
    logic [7:0]  a8, b8, r8, rhi8;
    logic        rst32, start32, ready32, valid32, c32, v32, z32;
    logic [3:0]  ctr32;
    logic [31:0] a32, b32, r32, rhi32;

    alu_mc #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst8), .start(start8), .alu_ctr(ctr8), .a(a8), .b(b8),
        .ready(ready8), .valid(valid8), .r(r8), .r_hi(rhi8),
        .c_out(c8), .overflow(v8), .zero(z8)
    );

    alu_mc #(.WIDTH(32)) u32 (
        .clk(clk), .reset(rst32), .start(start32), .alu_ctr(ctr32), .a(a32), .b(b32),
        .ready(ready32), .valid(valid32), .r(r32), .r_hi(rhi32),
        .c_out(c32), .overflow(v32), .zero(z32)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (valid8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL w8_unexpected_valid: got valid=1 (r=0x%0h) expected no pending result at %0t", r8, $time);
            end else begin
                e8 = q8.pop_front();
                check("w8_r",    {56'h0, r8},   {32'h0, e8.r});
                check("w8_r_hi", {56'h0, rhi8}, {32'h0, e8.hi});
                check("w8_c_out", {63'h0, c8}, {63'h0, e8.c});
                check("w8_ovf",   {63'h0, v8}, {63'h0, e8.v});
                check("w8_zero",  {63'h0, z8}, {63'h0, e8.z});
            end
        end
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (valid32 === 1'b1) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL w32_unexpected_valid: got valid=1 (r=0x%0h) expected no pending result at %0t", r32, $time);
            end else begin
                e32 = q32.pop_front();
                check("w32_r",    {32'h0, r32},   {32'h0, e32.r});
                check("w32_r_hi", {32'h0, rhi32}, {32'h0, e32.hi});
                check("w32_c_out", {63'h0, c32}, {63'h0, e32.c});
                check("w32_ovf",   {63'h0, v32}, {63'h0, e32.v});
                check("w32_zero",  {63'h0, z32}, {63'h0, e32.z});
            end
        end
    end

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [7:0] ehi,
                          input logic ec, input logic ev, input logic ez);
        exp_t e;
        @(negedge clk);
        ctr8 = op; a8 = a; b8 = b; start8 = 1'b1;
        e.r = {24'h0, er}; e.hi = {24'h0, ehi}; e.c = ec; e.v = ev; e.z = ez;
        q8.push_back(e);
    endtask

    task automatic idle8();
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (ready8 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w8_ready_timeout", {63'h0, ready8}, 64'h1);
    endtask

    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [31:0] ehi,
                           input logic ec, input logic ev, input logic ez, input bit push);
        exp_t e;
        @(negedge clk);
        ctr32 = op; a32 = a; b32 = b; start32 = 1'b1;
        e.r = er; e.hi = ehi; e.c = ec; e.v = ev; e.z = ez;
        if (push) q32.push_back(e);
    endtask

    task automatic idle32();
        @(negedge clk);
        start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
    endtask

    task automatic wait_ready32();
        int n = 0;
        while (ready32 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w32_ready_timeout", {63'h0, ready32}, 64'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;
        rst8 = 1'b1; start8 = 1'b0; ctr8 = 4'h0; a8 = 8'h00; b8 = 8'h00;
        rst32 = 1'b1; start32 = 1'b0; ctr32 = 4'h0; a32 = 32'h0; b32 = 32'h0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst32 = 1'b0;
        check("w8_reset_ready",  {63'h0, ready8}, 64'h1);
        check("w8_reset_valid",  {63'h0, valid8}, 64'h0);
        check("w8_reset_r",      {56'h0, r8}, 64'h0);
        check("w32_reset_ready", {63'h0, ready32}, 64'h1);
        check("w32_reset_r",     {32'h0, r32}, 64'h0);

        // Back-to-back single-cycle ops at WIDTH=8.
        issue8(OP_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        issue8(OP_SUB,  8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        issue8(OP_ANDN, 8'hF0, 8'h30, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0);
        issue8(OP_OR,   8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        issue8(OP_XOR,  8'h55, 8'hFF, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
        issue8(OP_XOR2, 8'h55, 8'h0F, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        issue8(OP_ORN,  8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        issue8(OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        issue8(OP_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        issue8(OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b0);
        idle8();

        // MULTU timing, with a start issued while busy that must be dropped.
        issue8(OP_MULTU, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
        busy = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start8 = (i == 3);
            ctr8 = OP_ADD;
            a8 = (i == 3) ? 8'h01 : 8'h3C;
            b8 = (i == 3) ? 8'h01 : 8'hC3;
            if (ready8 === 1'b0) busy++;
        end
        check("w8_mul_busy_cycles", 64'(busy), 64'd7);
        @(negedge clk);
        start8 = 1'b0;
        check("w8_mul_ready_at_end", {63'h0, ready8}, 64'h1);
        check("w8_mul_valid_at_end", {63'h0, valid8}, 64'h1);

        issue8(OP_MULTU, 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
        idle8(); wait_ready8();
        issue8(OP_DIVU, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);
        idle8(); wait_ready8();
        issue8(OP_DIVU, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b0, 1'b0, 1'b0);
        idle8(); wait_ready8();

        // Reset and start together: reset wins, nothing captured.
        @(negedge clk);
        rst8 = 1'b1; start8 = 1'b1; ctr8 = OP_ADD; a8 = 8'h01; b8 = 8'h01;
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        check("w8_rststart_valid", {63'h0, valid8}, 64'h0);
        check("w8_rststart_r",     {56'h0, r8},   64'h0);
        check("w8_rststart_r_hi",  {56'h0, rhi8}, 64'h0);
        check("w8_rststart_ready", {63'h0, ready8}, 64'h1);

        // Back-to-back AND, OR, XOR at WIDTH=32.
        issue32(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue32(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue32(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle32();

        issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        idle32(); wait_ready32();
        issue32(OP_DIVU, 32'h000F_4240, 32'h0000_0007, 32'h0002_2E09, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        idle32(); wait_ready32();

        // MULTU abandoned by reset at cycle 10; no result may ever appear.
        issue32(OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle32();
        repeat (8) @(negedge clk);
        rst32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        check("w32_midrun_ready", {63'h0, ready32}, 64'h1);
        check("w32_midrun_valid", {63'h0, valid32}, 64'h0);
        check("w32_midrun_r",     {32'h0, r32},   64'h0);
        check("w32_midrun_r_hi",  {32'h0, rhi32}, 64'h0);
        check("w32_midrun_flags", {61'h0, c32, v32, z32}, 64'h0);
        issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle32();
        repeat (40) @(negedge clk);

        check("w8_queue_empty",  64'(q8.size()),  64'd0);
        check("w32_queue_empty", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
